bit_serial_adder: RTL and testbench

- Multi-bit adder that streams operands LSB-first through the team's existing single-bit full adder `fa`, one bit per clock.
- Sits directly upstream of `fa`: it drives A/B/Cin and consumes S/Cout.
- Holds the carry in a flip-flop between bits and assembles the sum in a shift register.
- Reports completion with a one-cycle `done` pulse.

---
 rtl/bit_serial_adder_pkg.sv | 14 +
 rtl/bit_serial_adder_if.sv | 27 ++
 rtl/fa.sv | 15 +
 rtl/bit_serial_adder.sv | 108 ++++++++++
 tb/tb_bit_serial_adder.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/bit_serial_adder_pkg.sv
// Shared types and defaults for the serial arithmetic blocks.
// Provides the FSM state encoding and the default operand width.
// Optional macro: SERIAL_ADD_SUB_EN (consumed by the interface and the top).
package serial_arith_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_serial_adder_if.sv
// Request/result bundle between a requester and bit_serial_adder.
// The master drives start/a/b (and sub when SERIAL_ADD_SUB_EN is defined).
// The slave returns busy/done/sum/cout; no backpressure, requester polls busy.
interface bit_serial_adder_if #(
  parameter int WIDTH = serial_arith_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

`ifdef SERIAL_ADD_SUB_EN
  modport master (output start, a, b, sub, input busy, done, sum, cout);
  modport slave  (input start, a, b, sub, output busy, done, sum, cout);
`else
  modport master (output start, a, b, input busy, done, sum, cout);
  modport slave  (input start, a, b, output busy, done, sum, cout);
`endif

endinterface

// File: rtl/fa.sv
// Single-bit full adder.
// Purely combinational, zero latency.
// No flow control.
module fa (
  output logic S,
  output logic Cout,
  input  logic A,
  input  logic B,
  input  logic Cin
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/bit_serial_adder.sv
// Multi-bit adder streaming operands LSB-first through one full adder.
// Latency: WIDTH shift cycles, done pulses the cycle after the last shift.
// No queueing: start is only sampled in IDLE. Optional macro SERIAL_ADD_SUB_EN adds subtract.
module bit_serial_adder
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  bit_serial_adder_if.slave   bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_s_sh;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  logic             w_s;
  logic             w_cout;
  logic [WIDTH-1:0] w_s_next;

  fa u_fa (
    .S    (w_s),
    .Cout (w_cout),
    .A    (r_a_sh[0]),
    .B    (r_b_sh[0]),
    .Cin  (r_carry)
  );

  // New sum bit enters at the MSB; shift form keeps WIDTH=1 legal.
  always_comb begin
    w_s_next = (r_s_sh >> 1) | (WIDTH'(w_s) << (WIDTH - 1));
  end

  // Control FSM, operand/sum shift registers, carry and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_s_sh  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a_sh  <= bus.a;
`ifdef SERIAL_ADD_SUB_EN
            // Subtract as a + ~b + 1.
            r_b_sh  <= bus.sub ? ~bus.b : bus.b;
            r_carry <= bus.sub;
`else
            r_b_sh  <= bus.b;
            r_carry <= 1'b0;
`endif
            r_cnt   <= '0;
            r_state <= SHIFT;
            r_busy  <= 1'b1;
          end
        end
        SHIFT: begin
          r_s_sh  <= w_s_next;
          r_carry <= w_cout;
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == C_LAST) begin
            r_sum   <= w_s_next;
            r_cout  <= w_cout;
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Scoreboard bench for bit_serial_adder at WIDTH=8.
// Directed vectors push expected {cout,sum}; a negedge monitor pops on done.
// Subtract vectors run only when SERIAL_ADD_SUB_EN is defined.
module tb_bit_serial_adder;

  localparam int W = 8;

  logic clk;
  logic rst_n;

  bit_serial_adder_if #(.WIDTH(W)) bus ();

  bit_serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks;
  int errors;
  int done_cnt;
  logic [W:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done === 1'b1) begin
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: got sum=0x%0h cout=%0b with nothing outstanding",
                 bus.sum, bus.cout);
      end else begin
        logic [W:0] e;
        e = exp_q.pop_front();
        if ({bus.cout, bus.sum} !== e) begin
          errors++;
          $display("FAIL result: got cout=%0b sum=0x%0h expected cout=%0b sum=0x%0h",
                   bus.cout, bus.sum, e[W], e[W-1:0]);
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (bus.busy !== 1'b0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy still %0b after 50 cycles", bus.busy);
    end
  endtask

  // Issue one request; returns at #1 after the accepting edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic sub, input bit push,
                        input logic [W-1:0] es, input logic ec);
    wait_idle();
    bus.a = a;
    bus.b = b;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = sub;
`else
    if (sub) $display("note: subtract requested without SERIAL_ADD_SUB_EN");
`endif
    bus.start = 1'b1;
    if (push) exp_q.push_back({ec, es});
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Count edges until done is seen, and cycles with busy high along the way.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = (bus.busy === 1'b1) ? 1 : 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (bus.busy === 1'b1) bcnt++;
    end while (bus.done !== 1'b1 && lat < 50);
    if (lat >= 50) begin
      checks++; errors++;
      $display("FAIL done_timeout: no done within 50 cycles");
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  initial begin
    int lat, bcnt, d0;
    vec_t vecs[3];
    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
`ifdef SERIAL_ADD_SUB_EN
    bus.sub = 1'b0;
`endif

    // Reset state
    rst_n = 1'b0;
    #2;
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_done", {31'd0, bus.done}, 0);
    check("rst_sum",  {24'd0, bus.sum}, 0);
    check("rst_cout", {31'd0, bus.cout}, 0);
    #16 rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero operands: latency and busy duration
    launch(8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
    check("accept_busy", {31'd0, bus.busy}, 1);
    wait_done(lat, bcnt);
    check("zero_latency", lat, W);
    check("zero_busy_cycles", bcnt, W + 1);
    @(posedge clk); #1;
    check("post_done_busy", {31'd0, bus.busy}, 0);
    check("post_done_done", {31'd0, bus.done}, 0);
    check("sum_held", {24'd0, bus.sum}, 32'h00);

    // Carry ripple / overflow vectors
    vecs[0] = '{8'hFF, 8'h01, 8'h00, 1'b1};
    vecs[1] = '{8'hC8, 8'h64, 8'h2C, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 8'hFF, 1'b0};
    foreach (vecs[i]) begin
      launch(vecs[i].a, vecs[i].b, 1'b0, 1'b1, vecs[i].s, vecs[i].c);
      wait_done(lat, bcnt);
      check("vec_latency", lat, W);
    end

    // Start while busy is ignored; changed a/b do not disturb the flight
    @(posedge clk); #1;
    d0 = done_cnt;
    launch(8'h03, 8'h04, 1'b0, 1'b1, 8'h07, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    bus.a = 8'h11;
    bus.b = 8'h22;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(lat, bcnt);
    check("busy_start_latency", lat, W - 4);
    repeat (15) begin @(posedge clk); #1; end
    check("busy_start_one_done", done_cnt - d0, 1);

    // Reset mid-operation
    launch(8'h77, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    check("pre_reset_sum", {24'd0, bus.sum}, 32'h07);
    d0 = done_cnt;
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, bus.busy}, 0);
    check("midrst_sum",  {24'd0, bus.sum}, 0);
    check("midrst_cout", {31'd0, bus.cout}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    check("midrst_no_done", done_cnt - d0, 0);
    launch(8'h10, 8'h20, 1'b0, 1'b1, 8'h30, 1'b0);
    wait_done(lat, bcnt);
    check("after_rst_latency", lat, W);

    // start held high: back-to-back, one add per W+2 cycles
    wait_idle();
    bus.a = 8'h01;
    bus.b = 8'h02;
    bus.start = 1'b1;
    exp_q.push_back({1'b0, 8'h03});
    exp_q.push_back({1'b0, 8'h03});
    wait_done(lat, bcnt);
    check("b2b_first_latency", lat, W + 1);
    wait_done(lat, bcnt);
    bus.start = 1'b0;
    check("b2b_throughput", lat, W + 2);

`ifdef SERIAL_ADD_SUB_EN
    launch(8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0);
    wait_done(lat, bcnt);
    launch(8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1);
    wait_done(lat, bcnt);
    launch(8'h07, 8'h05, 1'b0, 1'b1, 8'h0C, 1'b0);
    wait_done(lat, bcnt);
`endif

    repeat (4) begin @(posedge clk); #1; end
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
